// File: rtl/dmem_controller.sv
// -----------------------------------------------------------------------------
// dmem_controller
//
// Purpose:
//   Data-memory access controller between the datapath DM_* port and a
//   variable-latency data memory using a req/ack handshake. While a load or
//   store is outstanding it stalls the pipeline. It returns load data on
//   DM_readData and raises sticky flags for misaligned or timed-out accesses.
//
// Parameters:
//   N        data and address width (bits)
//   TIMEOUT  max cycles in REQ without mem_ack before abort (>= 2)
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-low reset
//   DM_addr         byte address from datapath
//   DM_writeData    store data from datapath
//   DM_writeEnable  store request (wins if both enables are set)
//   DM_readEnable   load request
//   DM_readData     load data, non-zero only in DONE
//   stall           hold PC and pipeline while 1
//   err_clear       clears both sticky flags (a same-cycle set wins)
//   err_misalign    sticky: access with DM_addr[2:0] != 0
//   err_timeout     sticky: memory did not ack within TIMEOUT cycles
//   mem_req         memory request, high for the whole REQ state
//   mem_we          1 = write, 0 = read
//   mem_addr        registered address
//   mem_wdata       registered store data
//   mem_ack         single-cycle completion pulse from memory
//   mem_rdata       read data, valid in the mem_ack cycle
// -----------------------------------------------------------------------------
module dmem_controller #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic         stall,
    input  logic         err_clear,
    output logic         err_misalign,
    output logic         err_timeout,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       rdata_q, rdata_d;
    logic               mem_we_q, mem_we_d;
    logic [N-1:0]       mem_addr_q, mem_addr_d;
    logic [N-1:0]       mem_wdata_q, mem_wdata_d;
    logic               err_mis_q, err_mis_d;
    logic               err_to_q, err_to_d;

    logic               access;
    logic               aligned;
    logic               stall_c;
    logic               set_mis;
    logic               set_to;

    assign access  = DM_readEnable | DM_writeEnable;
    assign aligned = (DM_addr[2:0] == 3'b000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_mis_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_mis_q   <= err_mis_d;
            err_to_q    <= err_to_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        stall_c     = 1'b0;
        set_mis     = 1'b0;
        set_to      = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        // Stall in the launch cycle itself so the datapath
                        // holds the access while the request is in flight.
                        stall_c     = 1'b1;
                        mem_we_d    = DM_writeEnable;
                        mem_addr_d  = DM_addr;
                        mem_wdata_d = DM_writeData;
                        cnt_d       = '0;
                        state_d     = REQ;
                    end else begin
                        // Misaligned: dropped; a load simply reads back 0.
                        set_mis = 1'b1;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (mem_ack) begin
                    // Ack wins over a timeout landing in the same cycle.
                    rdata_d = mem_we_q ? '0 : mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    set_to  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The completed access is still on DM_* this cycle, so never
                // relaunch from here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Sticky flags: a set in the same cycle beats err_clear.
        err_mis_d = set_mis | (err_mis_q & ~err_clear);
        err_to_d  = set_to  | (err_to_q  & ~err_clear);
    end

    // Reset gates the combinational launch stall so it is 0 while reset is held.
    assign stall        = reset & stall_c;
    assign mem_req      = (state_q == REQ);
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign DM_readData  = (state_q == DONE) ? rdata_q : '0;
    assign err_misalign = err_mis_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_dmem_controller.sv
module tb_dmem_controller;

    localparam int N  = 64;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic         DM_readEnable;
    logic [N-1:0] DM_readData;
    logic         stall;
    logic         err_clear;
    logic         err_misalign;
    logic         err_timeout;
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_ack;
    logic [N-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_controller #(.N(N), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .DM_readEnable  (DM_readEnable),
        .DM_readData    (DM_readData),
        .stall          (stall),
        .err_clear      (err_clear),
        .err_misalign   (err_misalign),
        .err_timeout    (err_timeout),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    typedef struct packed {
        logic         we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic         chk_rd;
        logic [N-1:0] rdata;
        logic         to;
    } cpl_t;

    req_t req_q[$];
    cpl_t cpl_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: request launches, held request fields and completions.
    logic prev_req = 1'b0;
    req_t cur;
    cpl_t cc;

    always @(negedge clk) begin
        if (reset) begin
            if (mem_req && !prev_req) begin
                check("sb_req_expected", req_q.size() > 0, 1'b1);
                if (req_q.size() > 0) begin
                    cur = req_q.pop_front();
                    check("req_we", mem_we, cur.we);
                    check("req_addr", mem_addr, cur.addr);
                    if (cur.we) check("req_wdata", mem_wdata, cur.wdata);
                end
            end else if (mem_req && prev_req) begin
                check("hold_we", mem_we, cur.we);
                check("hold_addr", mem_addr, cur.addr);
                if (cur.we) check("hold_wdata", mem_wdata, cur.wdata);
            end else if (!mem_req && prev_req) begin
                check("sb_cpl_expected", cpl_q.size() > 0, 1'b1);
                if (cpl_q.size() > 0) begin
                    cc = cpl_q.pop_front();
                    check("done_stall", stall, 1'b0);
                    if (cc.chk_rd) check("done_rdata", DM_readData, cc.rdata);
                    check("done_err_timeout", err_timeout, cc.to);
                end
            end
        end
        prev_req = mem_req;
    end

    // Issue one aligned access; wt = REQ cycle index of the ack, -1 = never.
    task automatic do_access(input logic we, input logic re, input logic [N-1:0] addr,
                             input logic [N-1:0] wdata, input int wt,
                             input logic [N-1:0] rdat, input int exp_stall,
                             input int exp_req_cycles);
        int   stalls;
        int   k;
        logic done;
        logic is_wr;
        logic exp_to;
        is_wr  = we;
        exp_to = (wt < 0);
        req_q.push_back('{we: is_wr, addr: addr, wdata: wdata});
        cpl_q.push_back('{chk_rd: !is_wr, rdata: exp_to ? '0 : rdat, to: exp_to});

        @(posedge clk); #1;
        DM_writeEnable = we;
        DM_readEnable  = re;
        DM_addr        = addr;
        DM_writeData   = wdata;
        @(negedge clk);
        stalls = stall ? 1 : 0;
        k      = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            mem_ack   = mem_req && (k == wt);
            mem_rdata = rdat;
            @(negedge clk);
            if (mem_req) begin
                if (stall) stalls++;
                k++;
            end else begin
                done = 1'b1;
            end
        end
        check("access_completes", done, 1'b1);
        @(posedge clk); #1;
        DM_writeEnable = 1'b0;
        DM_readEnable  = 1'b0;
        mem_ack        = 1'b0;
        @(negedge clk);
        check("rdata_after_done", DM_readData, '0);
        check("stall_after_done", stall, 1'b0);
        check("stall_cycles", stalls, exp_stall);
        check("req_cycles", k, exp_req_cycles);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        DM_addr        = '0;
        DM_writeData   = '0;
        DM_writeEnable = 1'b0;
        DM_readEnable  = 1'b0;
        err_clear      = 1'b0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;

        // Reset state
        #2;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_rdata", DM_readData, '0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_flags", {err_misalign, err_timeout}, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        // Load, ack on first REQ cycle
        do_access(1'b0, 1'b1, 64'h40, '0, 0, 64'hDEADBEEF, 2, 1);

        // Store with 3 wait states
        do_access(1'b1, 1'b0, 64'h88, 64'h1234, 3, '0, 5, 4);

        // Timeout, then a late ack in IDLE
        do_access(1'b0, 1'b1, 64'h100, '0, -1, 64'hFFFF, TO + 1, TO);
        check("timeout_sticky", err_timeout, 1'b1);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        check("late_ack_no_req", mem_req, 1'b0);
        check("late_ack_no_stall", stall, 1'b0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_idle_req", mem_req, 1'b0);
        check("late_ack_rdata", DM_readData, '0);
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(negedge clk);
        check("timeout_cleared", err_timeout, 1'b0);

        // Misaligned load
        @(posedge clk); #1;
        DM_readEnable = 1'b1;
        DM_addr       = 64'h43;
        @(negedge clk);
        check("mis_stall", stall, 1'b0);
        check("mis_no_req", mem_req, 1'b0);
        check("mis_rdata", DM_readData, '0);
        @(posedge clk); #1;
        DM_readEnable = 1'b0;
        @(negedge clk);
        check("mis_flag", err_misalign, 1'b1);
        check("mis_no_req_after", mem_req, 1'b0);
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(negedge clk);
        check("mis_flag_before_edge", err_misalign, 1'b1);
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(negedge clk);
        check("mis_flag_cleared", err_misalign, 1'b0);

        // Misaligned store with err_clear in the same cycle: set wins, store dropped
        @(posedge clk); #1;
        DM_writeEnable = 1'b1;
        DM_addr        = 64'h7;
        DM_writeData   = 64'h55;
        err_clear      = 1'b1;
        @(posedge clk); #1;
        DM_writeEnable = 1'b0;
        err_clear      = 1'b0;
        @(negedge clk);
        check("set_beats_clear", err_misalign, 1'b1);
        check("mis_store_no_req", mem_req, 1'b0);
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(negedge clk);
        check("mis_flag_cleared2", err_misalign, 1'b0);

        // Both enables -> write
        do_access(1'b1, 1'b1, 64'h200, 64'hCAFE_F00D, 0, 64'h9999, 2, 1);

        // Ack in the timeout cycle -> normal completion
        do_access(1'b0, 1'b1, 64'h300, '0, TO - 1, 64'hA5A5_5A5A_0123_4567, TO + 1, TO);
        check("ack_at_timeout_no_err", err_timeout, 1'b0);

        // Reset asserted mid-REQ drops the request immediately
        req_q.push_back('{we: 1'b0, addr: 64'h400, wdata: '0});
        @(posedge clk); #1;
        DM_readEnable = 1'b1;
        DM_addr       = 64'h400;
        repeat (3) @(negedge clk);
        check("pre_rst_req", mem_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 1'b0);
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_rdata", DM_readData, '0);
        @(negedge clk);
        DM_readEnable = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_req", mem_req, 1'b0);
        check("post_rst_stall", stall, 1'b0);
        check("post_rst_flags", {err_misalign, err_timeout}, 2'b00);
        check("post_rst_rdata", DM_readData, '0);
        repeat (2) @(negedge clk);
        check("post_rst_idle", mem_req, 1'b0);

        check("sb_drained", req_q.size() + cpl_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
